// File: rtl/shift_pkg.sv
// Shared encodings and default constants for the iterative shift-amount unit.
package shift_pkg;

  typedef enum logic [1:0] {
    ModeSll = 2'b00,
    ModeSrl = 2'b01,
    ModeSra = 2'b10,
    ModeRor = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } shift_state_e;

  localparam int unsigned DefConstIdx = 1;
  localparam int unsigned DefConstAmt = 16;

endpackage

// File: rtl/shamt_mux.sv
// Combinational shift-amount selector: one slot replaced by a constant,
// out-of-range selects fall back to slot 0.
module shamt_mux #(
  parameter int unsigned AMT_W     = 6,
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned CONST_IDX = 1,
  parameter int unsigned CONST_AMT = 16
) (
  input  logic [SEL_W-1:0]       sel_i,
  input  logic [N_SRC*AMT_W-1:0] amt_i,
  output logic [AMT_W-1:0]       amt_o
);

  always_comb begin
    amt_o = amt_i[AMT_W-1:0];
    if (sel_i == SEL_W'(CONST_IDX)) begin
      amt_o = AMT_W'(CONST_AMT);
    end else begin
      for (int unsigned i = 1; i < N_SRC; i++) begin
        if (sel_i == SEL_W'(i)) amt_o = amt_i[i*AMT_W +: AMT_W];
      end
    end
  end

endmodule

// File: rtl/shamt_shift_unit.sv
// Iterative shifter: latches operand, mode and a selected amount, then shifts
// one bit position per clock under a start/busy/done handshake.
module shamt_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned AMT_W     = 6,
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned CONST_IDX = DefConstIdx,
  parameter int unsigned CONST_AMT = DefConstAmt
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [SEL_W-1:0]       sel_i,
  input  logic [N_SRC*AMT_W-1:0] amt_in_i,
  input  logic [1:0]             mode_i,
  input  logic [DATA_W-1:0]      data_in_i,
  output logic [DATA_W-1:0]      data_out_o,
  output logic                   busy_o,
  output logic                   done_o
);

  shift_state_e      state_q, state_d;
  shift_mode_e       mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d, step;
  logic [AMT_W-1:0]  cnt_q, cnt_d, amt_sel;
  logic              busy_q, done_q;

  shamt_mux #(
    .AMT_W    (AMT_W),
    .N_SRC    (N_SRC),
    .SEL_W    (SEL_W),
    .CONST_IDX(CONST_IDX),
    .CONST_AMT(CONST_AMT)
  ) u_shamt_mux (
    .sel_i(sel_i),
    .amt_i(amt_in_i),
    .amt_o(amt_sel)
  );

  always_comb begin
    unique case (mode_q)
      ModeSll: step = {data_q[DATA_W-2:0], 1'b0};
      ModeSrl: step = {1'b0, data_q[DATA_W-1:1]};
      ModeSra: step = {data_q[DATA_W-1], data_q[DATA_W-1:1]};
      ModeRor: step = {data_q[0], data_q[DATA_W-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          data_d  = data_in_i;
          mode_d  = shift_mode_e'(mode_i);
          cnt_d   = amt_sel;
          state_d = (amt_sel != '0) ? StShift : StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        data_d = step;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered decodes of the next state, so they track state_q exactly.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      mode_q  <= ModeSll;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == StShift);
      done_q  <= (state_d == StDone);
    end
  end

  assign data_out_o = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_shamt_shift_unit.sv
// Self-checking bench for shamt_shift_unit against a plain-arithmetic reference model.
module tb_shamt_shift_unit;

  localparam int Timeout = 200;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  sel;
  logic [23:0] amt_in;
  logic [1:0]  mode;
  logic [31:0] data_in, data_out;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  shamt_shift_unit dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (start),
    .sel_i     (sel),
    .amt_in_i  (amt_in),
    .mode_i    (mode),
    .data_in_i (data_in),
    .data_out_o(data_out),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  function automatic int ref_amt(input logic [2:0] s, input logic [23:0] a);
    if (s == 3'd1) return 16;
    if (s < 3'd4) return int'(a >> (6 * s)) & 63;
    return int'(a[5:0]);
  endfunction

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] m,
                                            input int a);
    int r;
    r = a % 32;
    case (m)
      2'b00:   return (a >= 32) ? 32'd0 : d << a;
      2'b01:   return (a >= 32) ? 32'd0 : d >> a;
      2'b10:   return (a >= 32) ? {32{d[31]}} : 32'($signed(d) >>> a);
      default: return (r == 0) ? d : ((d >> r) | (d << (32 - r)));
    endcase
  endfunction

  // Accept one operation, then count cycles until done; leaves us at the done negedge.
  task automatic do_op(input logic [31:0] d, input logic [1:0] m, input logic [2:0] s,
                       input logic [23:0] a, output int lat, output int bcnt,
                       output bit overlap);
    @(negedge clk);
    start = 1'b1; data_in = d; mode = m; sel = s; amt_in = a;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; data_in = $urandom; mode = 2'($urandom); sel = 3'($urandom);
    amt_in = 24'($urandom);
    lat = 0; bcnt = 0; overlap = 1'b0;
    while (!done && lat < Timeout) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic test_reset;
    int k;
    bit saw_done;
    reset = 1'b1; start = 1'b0; sel = '0; amt_in = '0; mode = '0; data_in = '0;
    @(negedge clk);
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    // SLL by 10, interrupted after three shift cycles between edges.
    @(negedge clk);
    start = 1'b1; data_in = 32'h0000_0001; mode = 2'b00; sel = 3'd0; amt_in = 24'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b1 && data_out !== 32'd0) begin end
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL midreset_data got=%h exp=0", data_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    saw_done = 1'b0;
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL midreset_nodone got=1 exp=0"); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL postreset_done got=%b exp=0", done); end
  endtask

  task automatic test_after_reset_op;
    int lat, bcnt; bit ov;
    do_op(32'h0000_0003, 2'b00, 3'd0, 24'd2, lat, bcnt, ov);
    n_checks++; if (data_out !== 32'h0000_000C) begin n_fail++; $display("FAIL post_reset_sll got=%h exp=0000000c", data_out); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL post_reset_lat got=%0d exp=2", lat); end
  endtask

  task automatic test_const_slot;
    int lat, bcnt; bit ov;
    do_op(32'h0000_0001, 2'b00, 3'd1, 24'hFFFFFF, lat, bcnt, ov);
    n_checks++; if (data_out !== 32'h0001_0000) begin n_fail++; $display("FAIL const_data got=%h exp=00010000", data_out); end
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL const_lat got=%0d exp=16", lat); end
    n_checks++; if (bcnt !== 16) begin n_fail++; $display("FAIL const_busy got=%0d exp=16", bcnt); end
    n_checks++; if (ov) begin n_fail++; $display("FAIL const_overlap got=1 exp=0"); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL const_done_pulse got=%b exp=0", done); end
    n_checks++; if (data_out !== 32'h0001_0000) begin n_fail++; $display("FAIL const_hold got=%h exp=00010000", data_out); end
  endtask

  task automatic test_sra_srl;
    int lat, bcnt; bit ov;
    do_op(32'h8000_0000, 2'b10, 3'd0, 24'd4, lat, bcnt, ov);
    n_checks++; if (data_out !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_data got=%h exp=f8000000", data_out); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL sra_lat got=%0d exp=4", lat); end
    do_op(32'h8000_0000, 2'b01, 3'd0, 24'd4, lat, bcnt, ov);
    n_checks++; if (data_out !== 32'h0800_0000) begin n_fail++; $display("FAIL srl_data got=%h exp=08000000", data_out); end
  endtask

  task automatic test_zero_amount;
    int lat, bcnt; bit ov;
    do_op(32'hDEAD_BEEF, 2'b00, 3'd2, {6'd7, 6'd0, 6'd9, 6'd5}, lat, bcnt, ov);
    n_checks++; if (data_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL zero_data got=%h exp=deadbeef", data_out); end
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL zero_lat got=%0d exp=0", lat); end
    n_checks++; if (bcnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got=%0d exp=0", bcnt); end
  endtask

  task automatic test_ror;
    int lat, bcnt; bit ov;
    do_op(32'h0000_00F1, 2'b11, 3'd3, {6'd36, 6'd0, 6'd0, 6'd0}, lat, bcnt, ov);
    n_checks++; if (data_out !== 32'h1000_000F) begin n_fail++; $display("FAIL ror_data got=%h exp=1000000f", data_out); end
    n_checks++; if (lat !== 36) begin n_fail++; $display("FAIL ror_lat got=%0d exp=36", lat); end
  endtask

  task automatic test_ignore_start;
    int lat;
    logic [31:0] exp;
    // sel = 5 is out of range, so slot 0 (= 8) supplies the amount.
    exp = ref_shift(32'h1234_5678, 2'b01, 8);
    @(negedge clk);
    start = 1'b1; data_in = 32'h1234_5678; mode = 2'b01; sel = 3'd5; amt_in = {18'd0, 6'd8};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; data_in = 32'hFFFF_0000; mode = 2'b00; sel = 3'd0; amt_in = 24'd1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < Timeout) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (data_out !== exp) begin n_fail++; $display("FAIL ignore_data got=%h exp=%h", data_out, exp); end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL ignore_lat got=%0d exp=8", lat); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt; bit ov;
    logic [31:0] exp;
    do_op(32'h0000_00FF, 2'b00, 3'd0, 24'd3, lat, bcnt, ov);
    exp = ref_shift(32'hA5A5_0000, 2'b10, 5);
    start = 1'b1; data_in = 32'hA5A5_0000; mode = 2'b10; sel = 3'd2; amt_in = {6'd0, 6'd5, 6'd0, 6'd0};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    lat = 0;
    while (!done && lat < Timeout) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL b2b_lat got=%0d exp=5", lat); end
    n_checks++; if (data_out !== exp) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", data_out, exp); end
  endtask

  task automatic test_random;
    int lat, bcnt, a; bit ov;
    logic [31:0] d, exp;
    logic [1:0]  m;
    logic [2:0]  s;
    logic [23:0] amts;
    for (int i = 0; i < 24; i++) begin
      d = $urandom; m = 2'($urandom); s = 3'($urandom); amts = 24'($urandom);
      a = ref_amt(s, amts);
      exp = ref_shift(d, m, a);
      do_op(d, m, s, amts, lat, bcnt, ov);
      n_checks++;
      if (data_out !== exp || lat !== a || bcnt !== a || ov) begin
        n_fail++;
        $display("FAIL rand_%0d got=%h lat=%0d busy=%0d exp=%h amt=%0d", i, data_out, lat, bcnt, exp, a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_after_reset_op();
    test_const_slot();
    test_sra_srl();
    test_zero_amount();
    test_ror();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shamt_shift_unit.md
# shamt_shift_unit

Parametrised, sequential successor to the datapath's shift-amount selector: picks a shift amount from one of N_SRC sources (one slot hard-wired to a constant), latches it with an operand and a shift mode, then performs the shift iteratively, one bit position per clock, under a start/busy/done handshake. It sits between the register file/instruction fields and the ALU result mux. The control unit waits on `done` instead of budgeting fixed shift cycles.

## Interface
- DATA_W, 32, operand/result width
- AMT_W, 6, width of each amount source and of the internal counter
- N_SRC, 4, number of amount sources (2..8)
- SEL_W, 3, selector width
- CONST_IDX, 1, source index replaced by the constant
- CONST_AMT, 16, constant amount driven at CONST_IDX

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  request; sampled on rising clk
- sel  in  SEL_W  amount source select
- amt_in  in  N_SRC*AMT_W  flattened amount sources, slot i = bits [i*AMT_W +: AMT_W]; slot CONST_IDX ignored
- mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- data_in  in  DATA_W  operand
- data_out  out  DATA_W  shift register contents
- busy  out  1  high while shifting
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, DONE.
- Amount select: sel == CONST_IDX gives CONST_AMT; sel < N_SRC otherwise gives slot sel; sel >= N_SRC gives slot 0.
- Start accepted when state is IDLE or DONE; ignored in SHIFT (no queuing, no latching of inputs).
- On accepted start: shift register <= data_in, mode latched, counter <= selected amount; next state SHIFT if amount != 0, else DONE.
- SHIFT, each cycle: shift register by one position per latched mode (SLL fill 0, SRL fill 0, SRA fill MSB, ROR bit0 to MSB); counter decrements; counter == 1 before the edge -> DONE.
- DONE: done = 1 for exactly one cycle; next state IDLE unless start accepted (then as above, back-to-back).
- Amounts >= DATA_W need no special case: iteration gives SLL/SRL -> 0, SRA -> all sign bits, ROR -> modulo DATA_W.
- Inputs sel, amt_in, mode, data_in only matter at the accepting edge.

## Timing
- Reset values: state IDLE, data_out 0, counter 0, busy 0, done 0.
- Start accepted at edge k with amount A: done high in the cycle after edge k+A; data_out final from that same edge and held until the next accepted start.
- A = 0: DONE at edge k, data_out = data_in.
- busy = (state == SHIFT); high for exactly A cycles (0 when A = 0).
- done and busy are never high together; both registered-state decodes, no input-to-output combinational path.
- data_out shows intermediate values during SHIFT; consumers sample only on done.
- Reset mid-SHIFT or in DONE: immediate return to reset values, no done pulse; next start after deassertion behaves normally.
- Max latency 2^AMT_W - 1 cycles.

## Structure
- Package shift_pkg: mode encodings (SLL, SRL, SRA, ROR), state encoding, default constants (CONST_IDX, CONST_AMT).
- Sub-module shamt_mux: purely combinational parametrised amount selector (sel, amt_in, constant substitution, out-of-range -> slot 0); instantiated once.
- Top holds FSM, counter, shift register.

## Test plan
- Reset asserted asynchronously mid-edge-free during SHIFT (SLL, A = 10, after 3 cycles) -> outputs 0 at once, no done; later SLL 0x0000_0003 by slot 0 = 2 -> 0x0000_000C.
- SLL data_in 0x0000_0001, sel = 1 (constant 16) -> busy 16 cycles, done after edge k+16, data_out 0x0001_0000.
- SRA data_in 0x8000_0000, sel = 0, slot 0 = 4 -> done after edge k+4, data_out 0xF800_0000; same with SRL -> 0x0800_0000.
- Amount 0 (sel = 2, slot 2 = 0), data_in 0xDEAD_BEEF -> busy never high, done after edge k, data_out 0xDEAD_BEEF.
- ROR data_in 0x0000_00F1 by 36 (slot 3) -> done after edge k+36, data_out 0x1000_000F.
- start pulsed during SHIFT with different data -> ignored, result unchanged; sel = 5 -> slot 0 used; start asserted in DONE cycle -> accepted, second done follows with no IDLE cycle.
